// File: rtl/aes128_enc_iter.sv
// rtl/aes128_enc_iter.sv - Iterative AES-128 encryption core, one round per clock
//
// Purpose: encrypts one 128-bit block with a 128-bit key. Round keys are
// expanded on the fly alongside the cipher rounds; the final round skips
// MixColumns. Ready/valid handshakes on both the input and output sides.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     plain_text/key valid
//   in_ready     core can accept a block this cycle
//   plain_text   input block, byte0 = [127:120], column-major state
//   key          cipher key, same byte order
//   out_valid    cipher_text valid
//   out_ready    downstream accepts cipher_text
//   cipher_text  encrypted block, registered
//   busy         high while rounds are in progress

module aes128_enc_iter #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_text,
  output logic         busy
);

  generate
    if (ROUNDS != 10) begin : g_bad_rounds
      $error("aes128_enc_iter supports only ROUNDS = 10");
    end
  endgenerate

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (b^254, with 0 -> 0) followed by the
  // affine transform. The inverse is the product of b^2, b^4, ..., b^128.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // SubBytes and ShiftRows together: byte (row r, col c) sits at index 4c+r;
  // row r is rotated left by r columns.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = sbox(s[8*(15-(4*((c+r)%4)+r)) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c)   +: 8];
      a1 = s[8*(14-4*c)   +: 8];
      a2 = s[8*(13-4*c)   +: 8];
      a3 = s[8*(12-4*c)   +: 8];
      o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w4, w5, w6, w7;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w4 = k[127:96] ^ t;
    w5 = w4 ^ k[95:64];
    w6 = w5 ^ k[63:32];
    w7 = w6 ^ k[31:0];
    return {w4, w5, w6, w7};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] nk;
  logic [127:0] sr;
  logic         load;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    rnd_d   = rnd_q;
    load    = 1'b0;
    nk      = expand(rk_q, rcon(rnd_q));
    sr      = sub_shift(st_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid) load = 1'b1;
      end
      S_ROUND: begin
        if (rnd_q == 4'd0 || rnd_q > LAST_RND) begin
          state_d = S_IDLE;
        end else begin
          rk_d  = nk;
          rnd_d = rnd_q + 4'd1;
          if (rnd_q == LAST_RND) begin
            ct_d    = sr ^ nk;
            state_d = S_DONE;
          end else begin
            st_d = mix_columns(sr) ^ nk;
          end
        end
      end
      S_DONE: begin
        // Popping and accepting on the same edge keeps back-to-back blocks flowing.
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      st_d    = plain_text ^ key;
      rk_d    = key;
      rnd_d   = 4'd1;
      state_d = S_ROUND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
    end
  end

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready    = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_ROUND);
  assign cipher_text = ct_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// tb/tb_aes128_enc_iter.sv - Directed-vector bench for aes128_enc_iter

module tb_aes128_enc_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;
  logic         busy;

  int errors = 0;
  int checks = 0;

  aes128_enc_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .plain_text  (plain_text),
    .key         (key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cipher_text (cipher_text),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a block and returns just after the accepting edge, with the
  // input bus scrambled so late sampling would corrupt the result.
  task automatic start_block(input logic [127:0] pt, input logic [127:0] k);
    int n;
    in_valid   = 1'b1;
    plain_text = pt;
    key        = k;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL start_block: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid   = 1'b0;
    plain_text = {$urandom, $urandom, $urandom, $urandom};
    key        = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_vector(input string name, input logic [127:0] pt,
                            input logic [127:0] k, input logic [127:0] exp_ct);
    int lat;
    start_block(pt, k);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: busy=%0b, required 1", name, busy);
    end
    wait_out(lat);
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL %s_latency: %0d edges, required 10", name, lat);
    end
    checks++;
    if (cipher_text !== exp_ct) begin
      errors++;
      $display("FAIL %s_ct: got %h, required %h", name, cipher_text, exp_ct);
    end
    pop();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_pop: out_valid=%0b in_ready=%0b, required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    plain_text = '0;
    key        = '0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || cipher_text !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b busy=%0b ct=%h, required 0 0 0 0",
               in_ready, out_valid, busy, cipher_text);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_vectors();
    run_vector("fips_c1", C1_PT, C1_KEY, C1_CT);
    run_vector("fips_b", B_PT, B_KEY, B_CT);
    run_vector("zero", 128'h0, 128'h0, Z_CT);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] held;
    start_block(B_PT, B_KEY);
    wait_out(lat);
    checks++;
    if (cipher_text !== B_CT || lat != 10) begin
      errors++;
      $display("FAIL bp_result: ct=%h lat=%0d, required %h 10", cipher_text, lat, B_CT);
    end
    held       = cipher_text;
    in_valid   = 1'b1;
    plain_text = C1_PT;
    key        = C1_KEY;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cipher_text !== held || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%0b in_ready=%0b busy=%0b ct=%h, required 1 0 0 %h",
                 i, out_valid, in_ready, busy, cipher_text, held);
      end
    end
    in_valid = 1'b0;
    pop();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_single_pop: out_valid=%0b busy=%0b in_ready=%0b, required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    start_block(C1_PT, C1_KEY);
    in_valid   = 1'b1;
    plain_text = B_PT;
    key        = B_KEY;
    wait_out(lat);
    checks++;
    if (cipher_text !== C1_CT || lat != 10) begin
      errors++;
      $display("FAIL b2b_first: ct=%h lat=%0d, required %h 10", cipher_text, lat, C1_CT);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready: in_ready=%0b, required 1", in_ready);
    end
    tick();
    in_valid   = 1'b0;
    plain_text = '0;
    key        = '0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reload: out_valid=%0b busy=%0b, required 0 1", out_valid, busy);
    end
    wait_out(lat);
    checks++;
    if (cipher_text !== B_CT || lat != 10) begin
      errors++;
      $display("FAIL b2b_second: ct=%h lat=%0d, required %h 10", cipher_text, lat, B_CT);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midop();
    start_block(B_PT, B_KEY);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || cipher_text !== 128'h0) begin
      errors++;
      $display("FAIL midop_reset: out_valid=%0b busy=%0b in_ready=%0b ct=%h, required 0 0 0 0",
               out_valid, busy, in_ready, cipher_text);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_no_output[%0d]: out_valid=%0b, required 0", i, out_valid);
      end
    end
    run_vector("midop_rerun", C1_PT, C1_KEY, C1_CT);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
